// File: rtl/reservation_station_array.sv
// reservation_station_array: multi-entry reservation station with CDB wakeup,
// allocate bypass and oldest-ready issue selection tracked by an age matrix.
module reservation_station_array #(
    parameter int NUM_ENTRIES = 4,
    parameter int TAG_WIDTH   = 7,
    parameter int NUM_CDB     = 2,
    parameter int INSTR_WIDTH = 32,
    parameter int CNT_WIDTH   = $clog2(NUM_ENTRIES + 1)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         alloc_valid,
    output logic                         alloc_ready,
    input  logic [INSTR_WIDTH-1:0]       alloc_instr,
    input  logic [TAG_WIDTH-1:0]         alloc_rd,
    input  logic [TAG_WIDTH-1:0]         alloc_rs1,
    input  logic                         alloc_rs1_ready,
    input  logic [TAG_WIDTH-1:0]         alloc_rs2,
    input  logic                         alloc_rs2_ready,
    input  logic [NUM_CDB-1:0]           cdb_valid,
    input  logic [NUM_CDB*TAG_WIDTH-1:0] cdb_tag,
    output logic                         issue_valid,
    input  logic                         issue_ready,
    output logic [INSTR_WIDTH-1:0]       issue_instr,
    output logic [TAG_WIDTH-1:0]         issue_rd,
    output logic [TAG_WIDTH-1:0]         issue_rs1,
    output logic [TAG_WIDTH-1:0]         issue_rs2,
    output logic [CNT_WIDTH-1:0]         occupancy
);
    localparam int IDX_W = $clog2(NUM_ENTRIES);

    logic [NUM_ENTRIES-1:0] r_valid;
    logic [NUM_ENTRIES-1:0] r_rs1_rdy;
    logic [NUM_ENTRIES-1:0] r_rs2_rdy;
    logic [INSTR_WIDTH-1:0] r_instr [NUM_ENTRIES];
    logic [TAG_WIDTH-1:0]   r_rd    [NUM_ENTRIES];
    logic [TAG_WIDTH-1:0]   r_rs1   [NUM_ENTRIES];
    logic [TAG_WIDTH-1:0]   r_rs2   [NUM_ENTRIES];
    // r_older[j][i] set means entry j was allocated before entry i
    logic [NUM_ENTRIES-1:0] r_older [NUM_ENTRIES];
    logic [CNT_WIDTH-1:0]   r_occ;

    logic [NUM_ENTRIES-1:0] w_cand;
    logic [NUM_ENTRIES-1:0] w_blk;
    logic [NUM_ENTRIES-1:0] w_sel;
    logic [NUM_ENTRIES-1:0] w_free_oh;
    logic [IDX_W-1:0]       w_free_idx;
    logic                   w_alloc;
    logic                   w_issue;

    function automatic logic f_hit(input logic [TAG_WIDTH-1:0] tag);
        f_hit = 1'b0;
        for (int k = 0; k < NUM_CDB; k++)
            f_hit = f_hit | (cdb_valid[k] && cdb_tag[k*TAG_WIDTH +: TAG_WIDTH] == tag);
    endfunction

    assign alloc_ready = (r_occ != CNT_WIDTH'(NUM_ENTRIES));
    assign occupancy   = r_occ;
    assign issue_valid = |w_cand;
    assign w_alloc     = alloc_valid && alloc_ready && !flush;
    assign w_issue     = issue_valid && issue_ready && !flush;

    always_comb begin
        w_cand = r_valid & r_rs1_rdy & r_rs2_rdy;
        w_blk  = '0;
        for (int i = 0; i < NUM_ENTRIES; i++)
            for (int j = 0; j < NUM_ENTRIES; j++)
                w_blk[i] = w_blk[i] | (w_cand[j] & r_older[j][i]);
        w_sel = w_cand & ~w_blk;
    end

    always_comb begin
        w_free_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--)
            if (!r_valid[i]) w_free_idx = IDX_W'(i);
        w_free_oh = w_alloc ? (NUM_ENTRIES'(1) << w_free_idx) : '0;
    end

    // w_sel is one-hot (or zero), so an OR-reduction acts as the payload mux
    always_comb begin
        issue_instr = '0;
        issue_rd    = '0;
        issue_rs1   = '0;
        issue_rs2   = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            issue_instr = issue_instr | ({INSTR_WIDTH{w_sel[i]}} & r_instr[i]);
            issue_rd    = issue_rd    | ({TAG_WIDTH{w_sel[i]}} & r_rd[i]);
            issue_rs1   = issue_rs1   | ({TAG_WIDTH{w_sel[i]}} & r_rs1[i]);
            issue_rs2   = issue_rs2   | ({TAG_WIDTH{w_sel[i]}} & r_rs2[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid   <= '0;
            r_rs1_rdy <= '0;
            r_rs2_rdy <= '0;
            r_occ     <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_older[i] <= '0;
                r_instr[i] <= '0;
                r_rd[i]    <= '0;
                r_rs1[i]   <= '0;
                r_rs2[i]   <= '0;
            end
        end else if (flush) begin
            r_valid <= '0;
            r_occ   <= '0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (r_valid[i] && f_hit(r_rs1[i])) r_rs1_rdy[i] <= 1'b1;
                if (r_valid[i] && f_hit(r_rs2[i])) r_rs2_rdy[i] <= 1'b1;
            end
            r_valid <= (r_valid & ~(w_issue ? w_sel : '0)) | w_free_oh;
            r_occ   <= r_occ + CNT_WIDTH'(w_alloc) - CNT_WIDTH'(w_issue);
            if (w_alloc) begin
                r_instr[w_free_idx]   <= alloc_instr;
                r_rd[w_free_idx]      <= alloc_rd;
                r_rs1[w_free_idx]     <= alloc_rs1;
                r_rs2[w_free_idx]     <= alloc_rs2;
                r_rs1_rdy[w_free_idx] <= alloc_rs1_ready || f_hit(alloc_rs1);
                r_rs2_rdy[w_free_idx] <= alloc_rs2_ready || f_hit(alloc_rs2);
                r_older[w_free_idx]   <= '0;
                for (int j = 0; j < NUM_ENTRIES; j++)
                    if (j != int'(w_free_idx)) r_older[j][w_free_idx] <= 1'b1;
            end
        end
    end
endmodule
